// File: rtl/sprite_blitter_if.sv
// Bundle of the draw-command, sprite-ROM and frame-buffer write signals of the sprite blitter.
// The master modport is the blitter side, the slave modport is the game logic / memory side.
interface sprite_blitter_if #(
    parameter int ADDR_W = 19
);
    logic              start;
    logic [9:0]        org_x;
    logic [8:0]        org_y;
    logic [6:0]        spr_w;
    logic [6:0]        spr_h;
    logic [3:0]        scale;
    logic              transp_en;
    logic              busy;
    logic              done;
    logic [5:0]        rom_col;
    logic [5:0]        rom_row;
    logic [3:0]        rom_pix;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [3:0]        fb_data;
    logic              fb_ready;

    modport master (
        input  start, org_x, org_y, spr_w, spr_h, scale, transp_en, rom_pix, fb_ready,
        output busy, done, rom_col, rom_row, fb_we, fb_addr, fb_data
    );

    modport slave (
        output start, org_x, org_y, spr_w, spr_h, scale, transp_en, rom_pix, fb_ready,
        input  busy, done, rom_col, rom_row, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/sprite_blitter.sv
// Copies a sprite pixel by pixel into the frame buffer with integer scaling,
// optional transparency of index 0 and clipping at the frame-buffer edges.
module sprite_blitter #(
    parameter int MAX_DIM = 64,
    parameter int FB_W    = 640,
    parameter int FB_H    = 480,
    parameter int ADDR_W  = 19
) (
    input  logic             Clk,
    input  logic             Reset_n,
    sprite_blitter_if.master bus
);
    localparam int DIM_W = $clog2(MAX_DIM);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, ADVANCE, FINISH} state_t;

    state_t            state_reg, state_next;
    logic [9:0]        ox_reg;
    logic [6:0]        w_reg, h_reg;
    logic [3:0]        scl_reg;
    logic              tr_reg;
    logic [DIM_W-1:0]  c_reg, r_reg;
    logic [2:0]        sc_reg, sr_reg;
    logic [10:0]       dx_reg, dy_reg;
    logic              fb_we_reg;
    logic [ADDR_W-1:0] fb_addr_reg;
    logic [3:0]        fb_data_reg;

    logic              cmd_bad, skip, last_sc, last_c, last_sr, last_r;
    logic [ADDR_W-1:0] pix_addr;

    assign cmd_bad  = (bus.spr_w == 7'd0) || (bus.spr_h == 7'd0) ||
                      (bus.scale == 4'd0) || (bus.scale > 4'd8);
    assign last_sc  = ({1'b0, sc_reg} == scl_reg - 4'd1);
    assign last_sr  = ({1'b0, sr_reg} == scl_reg - 4'd1);
    assign last_c   = (7'(c_reg) == w_reg - 7'd1);
    assign last_r   = (7'(r_reg) == h_reg - 7'd1);
    // dx/dy are wide enough that off-screen positions never wrap back on screen
    assign skip     = (tr_reg && (bus.rom_pix == 4'd0)) ||
                      (dx_reg >= 11'(FB_W)) || (dy_reg >= 11'(FB_H));
    assign pix_addr = ADDR_W'(dy_reg) * ADDR_W'(FB_W) + ADDR_W'(dx_reg);

    always_ff @(posedge Clk) begin
        if (!Reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = cmd_bad ? FINISH : FETCH;
            FETCH:   state_next = CAPTURE;
            CAPTURE: state_next = skip ? ADVANCE : WRITE;
            WRITE:   if (bus.fb_ready) state_next = ADVANCE;
            ADVANCE: state_next = (last_sc && last_c && last_sr && last_r) ? FINISH : FETCH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Destination coordinates advance incrementally: row-major order moves dx by one per step
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ox_reg      <= '0;
            w_reg       <= '0;
            h_reg       <= '0;
            scl_reg     <= '0;
            tr_reg      <= 1'b0;
            c_reg       <= '0;
            r_reg       <= '0;
            sc_reg      <= '0;
            sr_reg      <= '0;
            dx_reg      <= '0;
            dy_reg      <= '0;
            fb_we_reg   <= 1'b0;
            fb_addr_reg <= '0;
            fb_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        ox_reg  <= bus.org_x;
                        w_reg   <= bus.spr_w;
                        h_reg   <= bus.spr_h;
                        scl_reg <= bus.scale;
                        tr_reg  <= bus.transp_en;
                        c_reg   <= '0;
                        r_reg   <= '0;
                        sc_reg  <= '0;
                        sr_reg  <= '0;
                        dx_reg  <= {1'b0, bus.org_x};
                        dy_reg  <= {2'b00, bus.org_y};
                    end
                end
                CAPTURE: begin
                    fb_data_reg <= bus.rom_pix;
                    fb_addr_reg <= pix_addr;
                    fb_we_reg   <= !skip;
                end
                WRITE: begin
                    if (bus.fb_ready) fb_we_reg <= 1'b0;
                end
                ADVANCE: begin
                    if (!last_sc) begin
                        sc_reg <= sc_reg + 3'd1;
                        dx_reg <= dx_reg + 11'd1;
                    end else begin
                        sc_reg <= '0;
                        if (!last_c) begin
                            c_reg  <= c_reg + 1'b1;
                            dx_reg <= dx_reg + 11'd1;
                        end else begin
                            c_reg  <= '0;
                            dx_reg <= {1'b0, ox_reg};
                            if (!last_sr) begin
                                sr_reg <= sr_reg + 3'd1;
                                dy_reg <= dy_reg + 11'd1;
                            end else begin
                                sr_reg <= '0;
                                if (!last_r) begin
                                    r_reg  <= r_reg + 1'b1;
                                    dy_reg <= dy_reg + 11'd1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == FINISH);
    assign bus.rom_col = c_reg;
    assign bus.rom_row = r_reg;
    assign bus.fb_we   = fb_we_reg;
    assign bus.fb_addr = fb_addr_reg;
    assign bus.fb_data = fb_data_reg;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: sprite ROM model, frame-buffer write monitor
// and a loop-based reference that derives expected write counts and an ordered checksum.
module tb_sprite_blitter;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    sprite_blitter_if #(.ADDR_W(19)) bus ();

    sprite_blitter #(.MAX_DIM(64), .FB_W(640), .FB_H(480), .ADDR_W(19)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    logic [3:0] spr [0:63][0:63];
    logic [3:0] fbm [int];

    int          n_cmp = 0;
    int          n_err = 0;
    int          ready_mode = 1;
    int          wr_cnt, done_cnt, zero_wr, first_addr, last_addr, max_addr, stall_err;
    int unsigned chk_acc;
    bit          prev_stall = 0;
    logic [18:0] prev_addr;
    logic [3:0]  prev_data;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge Clk) bus.rom_pix <= spr[bus.rom_row][bus.rom_col];

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            case (ready_mode)
                0:       bus.fb_ready = 1'b0;
                1:       bus.fb_ready = 1'b1;
                default: bus.fb_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Inputs change just after the rising edge, so the falling edge sees settled values
    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_stall = 0;
        end else begin
            if (bus.done) done_cnt++;
            if (prev_stall && (!bus.fb_we || bus.fb_addr != prev_addr || bus.fb_data != prev_data))
                stall_err++;
            if (bus.fb_we && bus.fb_ready) begin
                wr_cnt++;
                if (first_addr < 0) first_addr = int'(bus.fb_addr);
                last_addr = int'(bus.fb_addr);
                if (int'(bus.fb_addr) > max_addr) max_addr = int'(bus.fb_addr);
                if (bus.fb_data == 4'd0) zero_wr++;
                fbm[int'(bus.fb_addr)] = bus.fb_data;
                chk_acc = chk_acc * 31 + 32'(bus.fb_addr) * 16 + 32'(bus.fb_data);
            end
            prev_stall = bus.fb_we && !bus.fb_ready;
            prev_addr  = bus.fb_addr;
            prev_data  = bus.fb_data;
        end
    end

    function automatic void model(input int ox, oy, w, h, scl, input bit tr,
                                  output int cnt, output int unsigned chk);
        cnt = 0;
        chk = 0;
        if (w == 0 || h == 0 || scl == 0 || scl > 8) return;
        for (int r = 0; r < h; r++)
            for (int sr = 0; sr < scl; sr++)
                for (int c = 0; c < w; c++)
                    for (int sc = 0; sc < scl; sc++) begin
                        int dx, dy;
                        logic [3:0] p;
                        dx = ox + c * scl + sc;
                        dy = oy + r * scl + sr;
                        p  = spr[r][c];
                        if (!((tr && p == 4'd0) || dx >= 640 || dy >= 480)) begin
                            cnt++;
                            chk = chk * 31 + 32'(dy * 640 + dx) * 16 + 32'(p);
                        end
                    end
    endfunction

    task automatic clear_spr();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                spr[r][c] = 4'd0;
    endtask

    task automatic run_cmd(input string tag, input int ox, oy, w, h, scl, input bit tr,
                           input bit poke, output int lat);
        int          cyc;
        bit          seen;
        int          exp_cnt;
        int unsigned exp_chk;
        wr_cnt = 0; chk_acc = 0; done_cnt = 0; zero_wr = 0;
        first_addr = -1; last_addr = 0; max_addr = 0; stall_err = 0;
        fbm.delete();
        @(posedge Clk); #1;
        bus.org_x = 10'(ox); bus.org_y = 9'(oy);
        bus.spr_w = 7'(w);   bus.spr_h = 7'(h);
        bus.scale = 4'(scl); bus.transp_en = tr;
        bus.start = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 30000) begin
            @(negedge Clk);
            cyc++;
            if (bus.done) seen = 1;
            if (poke && cyc == 7) bus.start = 1'b1;
            if (poke && cyc == 8) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        lat = cyc;
        check_val({tag, "_done_seen"}, longint'(seen), 1);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_val({tag, "_done_cnt"}, done_cnt, 1);
        check_val({tag, "_busy_after"}, longint'(bus.busy), 0);
        check_val({tag, "_stall_stable"}, stall_err, 0);
        model(ox, oy, w, h, scl, tr, exp_cnt, exp_chk);
        check_val({tag, "_model_cnt"}, wr_cnt, exp_cnt);
        check_val({tag, "_model_chk"}, longint'(chk_acc), longint'(exp_chk));
        $display("cmd %s org=(%0d,%0d) %0dx%0d scale=%0d transp=%0d writes=%0d cycles=%0d",
                 tag, ox, oy, w, h, scl, tr, wr_cnt, cyc);
    endtask

    initial begin
        int lat, cnt, cyc;
        bus.start = 1'b0; bus.org_x = '0; bus.org_y = '0; bus.spr_w = '0; bus.spr_h = '0;
        bus.scale = '0; bus.transp_en = 1'b0; bus.fb_ready = 1'b1;
        clear_spr();

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_val("rst_busy", longint'(bus.busy), 0);
        check_val("rst_done", longint'(bus.done), 0);
        check_val("rst_fb_we", longint'(bus.fb_we), 0);
        check_val("rst_rom_col", longint'(bus.rom_col), 0);
        check_val("rst_fb_addr", longint'(bus.fb_addr), 0);
        check_val("rst_fb_data", longint'(bus.fb_data), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // O-block: 8x8, every pixel nonzero
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                spr[r][c] = 4'((r + c) % 15 + 1);

        // Reset while a write is stalled
        ready_mode = 0;
        done_cnt = 0;
        @(posedge Clk); #1;
        bus.org_x = 10'd100; bus.org_y = 9'd50; bus.spr_w = 7'd8; bus.spr_h = 7'd8;
        bus.scale = 4'd1; bus.transp_en = 1'b0; bus.start = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.fb_we && cyc < 50) begin
            @(negedge Clk);
            cyc++;
        end
        check_val("midrst_reached_write", longint'(bus.fb_we), 1);
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_val("midrst_fb_we", longint'(bus.fb_we), 0);
        check_val("midrst_busy", longint'(bus.busy), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check_val("midrst_no_done", done_cnt, 0);
        ready_mode = 1;

        run_cmd("oblk", 100, 50, 8, 8, 1, 1'b0, 1'b0, lat);
        check_val("oblk_writes", wr_cnt, 64);
        check_val("oblk_first", first_addr, 32100);
        check_val("oblk_last", last_addr, 36587);

        // J block: 12 cols x 8 rows, columns 0..3 transparent (32 zeros)
        clear_spr();
        for (int r = 0; r < 8; r++)
            for (int c = 4; c < 12; c++)
                spr[r][c] = 4'((r * 3 + c) % 15 + 1);
        run_cmd("jblk_t1", 200, 100, 12, 8, 1, 1'b1, 1'b0, lat);
        check_val("jblk_t1_writes", wr_cnt, 64);
        check_val("jblk_t1_zero_wr", zero_wr, 0);
        run_cmd("jblk_t0", 200, 100, 12, 8, 1, 1'b0, 1'b0, lat);
        check_val("jblk_t0_writes", wr_cnt, 96);

        // Backpressure with start pulses while busy; same result as the ready=1 run
        ready_mode = 2;
        run_cmd("jblk_bp", 200, 100, 12, 8, 1, 1'b0, 1'b1, lat);
        check_val("jblk_bp_writes", wr_cnt, 96);
        ready_mode = 1;

        // Digit one: 5x5 with only the middle column set to 9, scale 4
        clear_spr();
        for (int r = 0; r < 5; r++) spr[r][2] = 4'd9;
        run_cmd("one_x4", 0, 0, 5, 5, 4, 1'b1, 1'b0, lat);
        check_val("one_x4_writes", wr_cnt, 80);
        check_val("one_x4_first", first_addr, 8);
        check_val("one_x4_last", last_addr, 12171);
        cnt = 0;
        for (int y = 0; y < 20; y++)
            for (int x = 8; x < 12; x++)
                if (fbm.exists(y * 640 + x) && fbm[y * 640 + x] == 4'd9) cnt++;
        check_val("one_x4_cover", cnt, 80);

        // Clipping at the bottom-right corner
        clear_spr();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++)
                spr[r][c] = 4'd5;
        run_cmd("clip", 630, 478, 16, 4, 1, 1'b0, 1'b0, lat);
        check_val("clip_writes", wr_cnt, 20);
        check_val("clip_first", first_addr, 306550);
        check_val("clip_max", max_addr, 307199);

        // Degenerate command
        run_cmd("scale0", 10, 10, 4, 4, 0, 1'b0, 1'b0, lat);
        check_val("scale0_writes", wr_cnt, 0);
        check_val("scale0_latency", lat, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Sequential consumer of the sprite table. On a start request it reads one sprite pixel at a time (4-bit colour index) and writes it into the playfield frame buffer at a given origin. Each pixel is expanded by an integer scale factor, index 0 is optionally treated as transparent, and off-screen pixels are clipped. It sits between the game-logic FSM (issues draw commands) and the frame-buffer write port shared with the colour mapper.

Parameters:
MAX_DIM, 64, largest sprite width/height in sprite pixels (covers PATRICKSU at 54)
FB_W, 640, frame-buffer width in pixels
FB_H, 480, frame-buffer height in pixels
ADDR_W, 19, frame-buffer address width

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle draw request; sampled only in IDLE
org_x  in  10  destination x of the sprite's top-left pixel
org_y  in  9  destination y of the sprite's top-left pixel
spr_w  in  7  sprite width in sprite pixels (columns)
spr_h  in  7  sprite height in sprite pixels (rows)
scale  in  4  expansion factor, valid 1..8
transp_en  in  1  1 = index 0 is not written
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse when a command completes
rom_col  out  6  sprite column being fetched
rom_row  out  6  sprite row being fetched
rom_pix  in  4  sprite pixel at (rom_row, rom_col), valid 1 cycle after address
fb_we  out  1  frame-buffer write request
fb_addr  out  ADDR_W  write address, y*FB_W + x
fb_data  out  4  colour index to write
fb_ready  in  1  frame-buffer accepts the write this cycle when fb_we & fb_ready

Behaviour:
- Reset (Reset_n=0 at an edge): state IDLE. busy, done and fb_we = 0. rom_col, rom_row, fb_addr and fb_data = 0. All counters = 0. Applies mid-command: the command is abandoned without a done pulse.
- IDLE: when start=1, latch org_x, org_y, spr_w, spr_h, scale and transp_en, and clear all counters.
  - If spr_w=0, spr_h=0, scale=0 or scale>8, go to FINISH with no writes.
  - Otherwise go to FETCH.
  - start while not IDLE is ignored; a new start is needed for each command.
- Counters:
  - sprite col c and row r;
  - sub-col sc and sub-row sr (0..scale-1).
  - Destination dx = org_x + c*scale + sc, dy = org_y + r*scale + sr.
  - Compute dx/dy with at least 11/10 bits so no wrap occurs before clipping.
- FETCH: drive rom_col=c, rom_row=r, then go to CAPTURE.
- CAPTURE: register rom_pix into fb_data. Compute skip = (transp_en & rom_pix==0) | dx>=FB_W | dy>=FB_H.
  - If skip, go to ADVANCE.
  - Else assert fb_we with fb_addr=dy*FB_W+dx and go to WRITE.
- WRITE: hold fb_we, fb_addr and fb_data stable until fb_ready=1. The cycle with fb_we&fb_ready completes the write; fb_we drops the next cycle and the FSM goes to ADVANCE.
- ADVANCE, iteration order is row-major over destination pixels:
  - sc++ first; on sc wrap, c++.
  - On c wrap (c=spr_w-1), sr++; on sr wrap, r++.
  - After the last (r, sr, c, sc), go to FINISH. Otherwise go to FETCH; a fresh fetch happens even when c is unchanged.
- FINISH: done=1 for exactly one cycle, busy=1 in that cycle, then return to IDLE. A start on the cycle after done is accepted.
- Writes per command = count of non-skipped destination pixels. Maximum is spr_w*spr_h*scale^2.
- fb_addr multiply: constant FB_W, implemented as shifts/adds or DSP; must be registered, no combinational path from fb_ready.

Test Plan:
1. Reset_n=0 for 2 cycles during an active WRITE -> next cycle fb_we=0, busy=0, no done; a subsequent start draws normally.
2. O-block 8x8 all nonzero, org=(100,50), scale=1, fb_ready=1 -> 64 writes, first addr 50*640+100=32100, last addr 57*640+107=36587; done exactly once; busy low after.
3. J_block_0 (12 cols x 8 rows, 32 zeros), transp_en=1, scale=1 -> 64 writes, no write with data 0; transp_en=0 -> 96 writes.
4. 5x5 digit "one", scale=4, org=(0,0) -> 5 source-9 pixels x16 = 80 writes. Column at sprite col 2 covers dest x 8..11, y 0..19.
5. Clipping: 16x4 I_block_h at org=(630,478), scale=1 -> only x 630..639, y 478..479 written = 20 writes; no address ≥ 307200.
6. Backpressure: fb_ready toggles pseudo-randomly -> fb_addr/fb_data stable while fb_we&!fb_ready. Write count and contents match the fb_ready=1 run. start pulses while busy are ignored. scale=0 -> done next-but-one cycle, zero writes.
